// File: rtl/dice_pkg.sv
// Shared constants and helpers for the dice roller core:
// die side table (BCD), FSM state encoding, BCD conversion and 7-segment encoder.
package dice_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROLL,
    ST_SHOW,
    ST_BLANK
  } state_t;

  localparam logic [15:0] DIE_SIDES [8] = '{
    16'h0004, 16'h0006, 16'h0008, 16'h0010,
    16'h0012, 16'h0020, 16'h0100, 16'h0002
  };

  function automatic int bcd_to_int(input logic [15:0] b);
    return int'(b[15:12]) * 1000 + int'(b[11:8]) * 100
         + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  // Segment bit 0 is 'a', bit 6 is 'g'; non-decimal codes show nothing.
  function automatic logic [6:0] seg7_encode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

endpackage

// File: rtl/dice_roller_core_counter.sv
// DIGITS-wide BCD down-counter: load, enable, and wrap to load_val after 1.
// Ports: clk, rst (async high), load, en, load_val, value.
module bcd_down_counter #(
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   value
);

  localparam int BW = 4 * DIGITS;

  logic [BW-1:0] dec;
  logic          borrow;
  logic          is_one;

  // Ripple borrow through the digits; a zero digit becomes 9 and passes it on.
  always_comb begin
    dec    = value;
    borrow = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (borrow) begin
        if (value[4*k +: 4] == 4'd0) begin
          dec[4*k +: 4] = 4'd9;
        end else begin
          dec[4*k +: 4] = value[4*k +: 4] - 4'd1;
          borrow        = 1'b0;
        end
      end
    end
  end

  assign is_one = (value == BW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= BW'(1);
    end else if (load) begin
      value <= load_val;
    end else if (en) begin
      value <= is_one ? load_val : dec;
    end
  end

endmodule

// File: rtl/dice_roller_core.sv
// Dice roller: press starts a wrapping BCD roll, release freezes it and shows it
// on a scanned 7-segment display until a tick-based timeout blanks it.
// Ports: clk, rst, tick, btn -> bcd, seg, com, rolling, die_sel.
module dice_roller_core
  import dice_pkg::*;
#(
  parameter int DIGITS  = 2,
  parameter int NBTN    = 7,
  parameter int TIMEOUT = 255,
  parameter int SCAN_W  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic [NBTN-1:0]       btn,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     com,
  output logic                  rolling,
  output logic [2:0]            die_sel
);

  localparam int BW = 4 * DIGITS;
  localparam int MAXV = 10 ** DIGITS;
  localparam logic [7:0] TMO = 8'(TIMEOUT);

  // Full-range die (10^DIGITS) encodes as zero; larger ones clamp to all nines.
  function automatic logic [BW-1:0] sides_of(input logic [2:0] i);
    logic [15:0] raw;
    int          v;
    raw = DIE_SIDES[i];
    v   = bcd_to_int(raw);
    if (v == MAXV) return '0;
    if (v > MAXV) return {DIGITS{4'h9}};
    return raw[BW-1:0];
  endfunction

  state_t         state, state_n;
  logic [NBTN-1:0] btn_prev;
  logic           any_btn, press;
  logic [2:0]     win, die_n;
  logic [7:0]     tmo, tmo_n;
  logic           cnt_load, cnt_en;
  logic [BW-1:0]  load_val;
  logic [1:0]     idx;
  logic           step;
  logic [DIGITS-1:0] shown;
  logic [3:0]     dig;
  logic           vis;
  logic [DIGITS-1:0] com_n;
  logic [6:0]     seg_n;

  assign any_btn = |btn;
  assign press   = any_btn && !(|btn_prev);
  assign rolling = (state == ST_ROLL);

  always_comb begin
    win = '0;
    for (int i = NBTN - 1; i >= 0; i--) begin
      if (btn[i]) win = 3'(i);
    end
  end

  always_comb begin
    state_n  = state;
    die_n    = die_sel;
    tmo_n    = tmo;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    if (press && state != ST_ROLL) begin
      state_n  = ST_ROLL;
      die_n    = win;
      cnt_load = 1'b1;
    end else begin
      case (state)
        ST_ROLL: begin
          if (any_btn) begin
            cnt_en = 1'b1;
          end else begin
            state_n = ST_SHOW;
            tmo_n   = TMO;
          end
        end
        ST_SHOW: begin
          if (tmo == 8'd0) begin
            state_n = ST_BLANK;
          end else if (tick) begin
            tmo_n = tmo - 8'd1;
          end
        end
        ST_IDLE, ST_BLANK: ;
        default: state_n = ST_IDLE;
      endcase
    end
  end

  assign load_val = cnt_load ? sides_of(win) : sides_of(die_sel);

  bcd_down_counter #(
    .DIGITS(DIGITS)
  ) u_cnt (
    .clk(clk),
    .rst(rst),
    .load(cnt_load),
    .en(cnt_en),
    .load_val(load_val),
    .value(bcd)
  );

  generate
    if (SCAN_W == 0) begin : g_nodiv
      assign step = 1'b1;
    end else begin : g_div
      logic [SCAN_W-1:0] div;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) div <= '0;
        else     div <= div + 1'b1;
      end
      assign step = &div;
    end
  endgenerate

  // Upper digits that are zero along with everything above them stay dark,
  // except for the all-zero (full range) value.
  always_comb begin
    shown = '1;
    for (int k = 1; k < DIGITS; k++) begin
      if (bcd != '0 && (bcd >> (4 * k)) == '0) shown[k] = 1'b0;
    end
  end

  always_comb begin
    dig = 4'd0;
    vis = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == 2'(k)) begin
        dig = bcd[4*k +: 4];
        vis = shown[k];
      end
    end
  end

  always_comb begin
    com_n = '0;
    seg_n = '0;
    if (state_n == ST_SHOW && vis) begin
      com_n = DIGITS'(1) << idx;
      seg_n = seg7_encode(dig);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      btn_prev <= '0;
      die_sel  <= '0;
      tmo      <= '0;
      idx      <= '0;
      com      <= '0;
      seg      <= '0;
    end else begin
      state    <= state_n;
      btn_prev <= btn;
      die_sel  <= die_n;
      tmo      <= tmo_n;
      com      <= com_n;
      seg      <= seg_n;
      if (step) begin
        idx <= (idx == 2'(DIGITS - 1)) ? 2'd0 : idx + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_dice_roller_core.sv
// Bench for dice_roller_core: directed test-plan steps plus random rolls,
// checked against an integer model of the die, display and timeout rules.
module tb_dice_roller_core;

  localparam int D    = 2;
  localparam int NB   = 7;
  localparam int TO   = 3;
  localparam int MAXV = 10 ** D;

  logic           clk = 1'b0;
  logic           rst, tick;
  logic [NB-1:0]  btn;
  logic [4*D-1:0] bcd;
  logic [6:0]     seg;
  logic [D-1:0]   com;
  logic           rolling;
  logic [2:0]     die_sel;

  int vectors = 0;
  int errors  = 0;
  int val     = 1;
  int die     = 0;

  int         sides_t [8] = '{4, 6, 8, 10, 12, 20, 100, 2};
  logic [6:0] enc_t [10]  = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                              7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  dice_roller_core #(
    .DIGITS(D), .NBTN(NB), .TIMEOUT(TO), .SCAN_W(0)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .btn(btn),
    .bcd(bcd), .seg(seg), .com(com),
    .rolling(rolling), .die_sel(die_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sides(input int i);
    int s;
    s = sides_t[i];
    if (s > MAXV) s = MAXV - 1;
    return s;
  endfunction

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r;
    int          x;
    r = '0;
    x = v % MAXV;
    for (int k = 0; k < D; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int lowest(input logic [NB-1:0] b);
    for (int i = 0; i < NB; i++) if (b[i]) return i;
    return 0;
  endfunction

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic [NB-1:0] b, input int n,
                      input bit fresh, input bit with_tick);
    for (int i = 0; i < n; i++) begin
      btn  = b;
      tick = with_tick && (i == 0);
      edge1();
      tick = 1'b0;
      if (fresh && i == 0) begin
        die = lowest(b);
        val = sides(die);
      end else begin
        val = (val == 1) ? sides(die) : val - 1;
      end
      chk("roll_bcd", bcd, to_bcd(val));
      chk("roll_flag", rolling, 1);
      chk("roll_die", die_sel, die);
      chk("roll_com", com, 0);
    end
  endtask

  task automatic release_btn();
    btn = '0;
    edge1();
    chk("rel_flag", rolling, 0);
    chk("rel_bcd", bcd, to_bcd(val));
    chk("rel_die", die_sel, die);
  endtask

  task automatic show_check(input int n);
    int         v;
    logic [D-1:0] want, seen;
    v    = val % MAXV;
    want = '0;
    seen = '0;
    for (int k = 0; k < D; k++) begin
      if (k == 0 || v == 0 || (v / (10 ** k)) != 0) want[k] = 1'b1;
    end
    for (int c = 0; c < n; c++) begin
      edge1();
      if (com != '0) begin
        chk("com_legal", 32'(($onehot(com) && (com & ~want) == '0)), 1);
        for (int k = 0; k < D; k++) begin
          if (com[k]) chk("seg_digit", seg, enc_t[(v / (10 ** k)) % 10]);
        end
        seen |= com;
      end else begin
        chk("seg_dark", seg, 0);
      end
    end
    chk("scan_set", seen, want);
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    edge1();
    tick = 1'b0;
    edge1();
  endtask

  task automatic blank_check();
    logic [D-1:0] any;
    any = '0;
    for (int c = 0; c < 4; c++) begin
      edge1();
      any |= com;
    end
    chk("blank_com", any, 0);
    chk("blank_seg", seg, 0);
    chk("blank_bcd", bcd, to_bcd(val));
    chk("blank_flag", rolling, 0);
  endtask

  initial begin
    logic [NB-1:0] m, m2;
    rst  = 1'b1;
    tick = 1'b0;
    btn  = '0;
    repeat (3) edge1();
    rst = 1'b0;
    #1;
    chk("rst_bcd", bcd, 8'h01);
    chk("rst_com", com, 0);
    chk("rst_seg", seg, 0);
    chk("rst_roll", rolling, 0);
    chk("rst_die", die_sel, 0);
    edge1();

    hold(7'b0000001, 6, 1, 0);
    release_btn();
    chk("d4_frozen", bcd, 8'h03);
    show_check(6);

    pulse_tick();
    show_check(4);
    repeat (TO) pulse_tick();
    blank_check();

    hold(7'b1000000, 2, 1, 0);
    chk("d100_99", bcd, 8'h99);
    release_btn();
    show_check(6);

    hold(7'b0001010, 3, 1, 0);
    hold(7'b0001000, 5, 0, 0);
    chk("die_kept", die_sel, 1);
    release_btn();

    hold(7'b0000100, 2, 1, 1);
    release_btn();
    show_check(6);

    hold(7'b0010000, 1, 1, 0);
    release_btn();
    show_check(6);

    for (int it = 0; it < 25; it++) begin
      m = NB'($urandom_range(1, (1 << NB) - 1));
      hold(m, $urandom_range(1, 25), 1, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) begin
        m2 = NB'($urandom_range(1, (1 << NB) - 1));
        hold(m2, $urandom_range(1, 12), 0, 0);
      end
      release_btn();
      show_check($urandom_range(3, 8));
      if ($urandom_range(0, 2) == 0) begin
        repeat (TO + 1) pulse_tick();
        blank_check();
      end
    end

    hold(7'b0000100, 3, 1, 0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    val = 1;
    die = 0;
    chk("arst_bcd", bcd, 8'h01);
    chk("arst_roll", rolling, 0);
    chk("arst_die", die_sel, 0);
    chk("arst_com", com, 0);
    chk("arst_seg", seg, 0);
    btn = '0;
    repeat (2) edge1();
    rst = 1'b0;
    edge1();
    hold(7'b0100000, 4, 1, 0);
    release_btn();
    show_check(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/dice_roller_core.md
# dice_roller_core

Parametrised dice-roller core: the next generation of the single-board d4–d100 roller. It takes debounced die-select buttons and runs a BCD down-counter that wraps inside the selected die's range while a button is held. The value frozen at release is the roll. It drives a DIGITS-wide multiplexed seven-segment display with leading-zero blanking and an inactivity timeout. It sits between the per-button debouncers and the top-level pin-polarity muxing.

## Interface
- DIGITS, 2: number of BCD display digits (1–4).
- NBTN, 7: number of die buttons (1–8); button i selects DIE_SIDES[i].
- TIMEOUT, 255: display-on time after release, in `tick` periods (1–255).
- SCAN_W, 0: scan advances one digit every 2^SCAN_W clocks.
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous and active-high.
- tick  in  1  one-cycle timebase pulse from the shared prescaler.
- btn  in  NBTN  debounced buttons, active-high.
- bcd  out  4*DIGITS  current value, BCD, digit 0 in the LSBs.
- seg  out  7  segments a..g, active-high, for the scanned digit.
- com  out  DIGITS  one-hot digit common enable, active-high.
- rolling  out  1  high while in ROLL.
- die_sel  out  3  index of the die last selected.

## Operation
- Reset values:
  - state IDLE, bcd = 1, seg = 0, com = 0, rolling = 0, die_sel = 0.
  - Scan index 0, timeout counter 0.
- States: IDLE, ROLL, SHOW, BLANK.
- Press event: `btn` goes from all-zero to non-zero. The lowest set index wins. Presses are accepted in IDLE, SHOW and BLANK.
- On a press:
  - die_sel takes the winning index.
  - bcd is loaded with DIE_SIDES[die_sel].
  - The state goes to ROLL.
- ROLL, while any button is high:
  - bcd decrements by 1 each clock. Each digit borrows 0→9.
  - At value 1, the next value is DIE_SIDES[die_sel] (wrap).
  - Buttons other than the originating one are ignored, and die_sel does not change.
- Range and encoding:
  - Range is 1..sides. A sides value of 10^DIGITS (d100 with DIGITS = 2) is encoded as all zeros and displayed as "00".
  - A DIE_SIDES entry ≥ 10^DIGITS that is not exactly 10^DIGITS is clamped to the all-nines value.
- ROLL, when all buttons are low: the state goes to SHOW. bcd holds its last value. The timeout counter loads TIMEOUT.
- SHOW:
  - The counter decrements on each `tick`.
  - At 0 the state goes to BLANK.
  - A new press returns to ROLL and restarts everything.
- BLANK: com = 0, seg = 0, bcd retained. Only a press leaves BLANK.
- Display, in SHOW only:
  - A free-running scan index steps 0..DIGITS-1 and wraps.
  - com[k] is high only when index = k and digit k is not blanked.
  - seg is the 7-segment encoding of digit k.
- Leading-zero blanking:
  - Digit k > 0 is blanked if it and all higher digits are 0, unless the whole value is zero (the 10^DIGITS case, where every digit is shown).
  - Digit 0 is never blanked.
- In IDLE, ROLL and BLANK: com = 0 and seg = 0.
- Reset asserted mid-roll: immediate return to the reset values, with no glitch-free guarantee on seg/com during assertion.

## Timing
- All state, bcd, com and seg are registered. The only asynchronous path is rst.
- Press sampled at edge N:
  - At N+1: rolling = 1, bcd = sides.
  - At N+1+j: bcd = the value after j decrements (with wrap).
- Release sampled at edge M: rolling = 0 and the state is SHOW at M+1. bcd equals its value after edge M-1 (no decrement at edge M).
- Display on-time: after the last release, the display stays on for TIMEOUT `tick` pulses ±1 tick period.
- A tick coinciding with the SHOW entry cycle is not counted.
- Scan: com/seg for index k are valid from the edge after the index update. No dead cycle between digits.
- Simultaneous press and tick in SHOW: the press wins.
- Simultaneous press of two buttons: the lower index wins.

## Structure
- Package dice_pkg holds:
  - DIE_SIDES: 8 × 16-bit BCD constants (4, 6, 8, 10, 12, 20, 100, 2).
  - State encoding.
  - Function seg7_encode (4-bit BCD → 7 segments; values ≥ 10 map to blank).
- Sub-module bcd_down_counter (DIGITS-wide, with load, enable and wrap-to-load-value) is the natural split. The FSM, timeout, scan and blanking logic live in dice_roller_core.

## Test plan
- Reset with rst = 1 for 3 cycles → bcd = 0x01, com = 0, seg = 0, rolling = 0.
- Press btn[0] (d4) for 6 clocks → bcd sequence 4, 3, 2, 1, 4, 3. After release, rolling = 0 and bcd = 3.
- Press btn[6] (d100) for 2 clocks → bcd 0x00, then 0x99. After release, the value 99 is frozen and both digits scan.
- Press btn[1] and btn[3] together → die_sel = 1, range 6..1. Raising btn[3] mid-roll does not change die_sel.
- After release with TIMEOUT = 3 → com is active for 3 tick pulses, then BLANK (com = 0). A new press returns to ROLL the next cycle.
- Display: value 7 with DIGITS = 2 → only com[0] is ever asserted and seg = 0x07 (a, b, c). Value 12 → com alternates 01/10 with seg 0x5B and 0x06.
